inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction-fetch front end. Sits between pgmCounter and the decode stage and
//  steers the program counter through its branch/pcIn inputs. Reads synchronous
//  program memory at the current PC, buffers returned words in a 2-entry queue,
//  and hands them to decode with a valid/ready handshake. Decode back-pressure
//  becomes a PC "hold" (reload of the same address). Execute-stage redirects flush.
// PARAMETERS
//  INST_ADDR_LEN  `instAddrLen (8)  width of instruction address / PC
//  INST_LEN       `instLen (16)     width of one instruction word
// PORTS
//  clk         in   1              system clock, rising edge
//  reset       in   1              asynchronous, active-high reset
//  pc          in   INST_ADDR_LEN  current PC (pgmCounter pcOut)
//  pc_branch   out  1              load request to pgmCounter (its branch)
//  pc_target   out  INST_ADDR_LEN  load value to pgmCounter (its pcIn)
//  mem_addr    out  INST_ADDR_LEN  program memory read address
//  mem_data    in   INST_LEN       program memory data, 1 cycle after mem_addr
//  ex_branch   in   1              redirect request from execute stage
//  ex_target   in   INST_ADDR_LEN  redirect address
//  inst_valid  out  1              inst_word/inst_addr hold a valid instruction
//  inst_ready  in   1              decode accepts the head instruction
//  inst_word   out  INST_LEN       head instruction
//  inst_addr   out  INST_ADDR_LEN  address of head instruction
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-high; all state clears
//    immediately on reset assertion.
//  - Reset values: inst_valid=0, inst_word=0, inst_addr=0, queue count=0,
//    in-flight flag f1_valid=0. pc_branch/pc_target/mem_addr are combinational.
//  - mem_addr = pc (combinational). Data returns next cycle. f1_valid/f1_addr
//    register whether that return is kept.
//  - pop = inst_valid & inst_ready. credit_ok = (count + f1_valid - pop) < 2.
//  - issue = credit_ok & ~ex_branch. On the next edge: f1_valid <= issue,
//    f1_addr <= pc.
//  - pc_branch = ex_branch | ~credit_ok.
//    pc_target = ex_branch ? ex_target : pc.
//    ex_branch has priority over hold. A hold makes pgmCounter reload the same
//    PC; the non-issued read is discarded.
//  - When f1_valid=1, {f1_addr, mem_data} is pushed into the queue that cycle.
//    By the credit rule the queue never overflows and pushes are never dropped.
//  - Queue: 2-entry FIFO, in-order. inst_valid = (count != 0). The head is
//    driven from a register; there is no mem_data->inst_word combinational path.
//  - Latency: PC issued at cycle t -> queued at t+1 -> visible at t+2.
//    Sustains one instruction per cycle when inst_ready=1.
//  - Redirect (ex_branch=1):
//    - Next edge: queue flushed (count=0) and f1_valid=0.
//    - A pop on the same cycle is void; decode must ignore the head.
//    - First target instruction is visible 2 cycles after pgmCounter loads the
//      target.
//  - Simultaneous push and pop: count unchanged. Push into full queue is
//    impossible (assertion in sim).
//  - PC wrap (all-ones -> 0) is handled by pgmCounter. No special case here;
//    inst_addr wraps with it.
//  - Reset mid-operation: queue and in-flight data are lost. Fetch restarts at
//    address 0 on the first edge after release.
// STRUCTURE
//  - instAddrLen/instLen come from defines.v (shared constants). No new typedefs.
//  - One sub-module: fetch_queue (2-entry FIFO {addr,word}; push/pop/flush/count).
//  - Top level holds the credit logic, in-flight register and PC steering.
// TESTING
//  1. Reset release, inst_ready=1, mem[i]=16'h0100+i.
//     -> inst_valid first high 2 cycles later with addr 0/word 0100, then
//     addr 1,2,3... one per cycle.
//  2. inst_ready=0 for 5 cycles mid-stream.
//     -> count reaches 2; pc_branch=1 with pc_target==pc each stalled cycle.
//     On release: consecutive addresses with no gap, loss or duplicate.
//  3. Queue full, ex_branch=1, ex_target=8'h40 for one cycle.
//     -> next valid instruction is addr 40/word 0140; no stale word delivered.
//  4. ex_branch asserted in the same cycle as a hold.
//     -> pc_target=ex_target (not pc); stream continues from the target.
//  5. Stream across 8'hFF.
//     -> inst_addr FF then 00, words 01FF then 0100, no bubble.
//  6. reset pulsed while count=2.
//     -> inst_valid=0 before the next clk edge; after release, restart at
//     addr 0 with latency as in test 1.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
//   DEF_INST_ADDR_LEN : default instruction address / PC width
//   DEF_INST_LEN      : default instruction word width
//   QUEUE_DEPTH       : entries in the fetch queue
//   creditOk()        : true when one more read may be issued without the
//                       fetch queue overflowing on its return
package inst_fetch_unit_pkg;

  localparam int DEF_INST_ADDR_LEN = 8;
  localparam int DEF_INST_LEN      = 16;
  localparam int QUEUE_DEPTH       = 2;

  // A read issued now lands in the queue two edges from now. Counting what is
  // already buffered plus what is in flight, minus what leaves this cycle,
  // tells us whether that future push still has a free slot.
  function automatic logic creditOk(input logic [1:0] count,
                                    input logic       f1Valid,
                                    input logic       pop);
    logic [2:0] occupancy;
    occupancy = {1'b0, count} + {2'b00, f1Valid} - {2'b00, pop};
    return occupancy < 3'(QUEUE_DEPTH);
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Two-entry in-order FIFO of {address, word} pairs feeding decode.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push, pushAddr/Word enqueue one fetched instruction
//   pop                 dequeue the head
//   flush               discard all entries (wins over push and pop)
//   count               number of buffered entries (0..2)
//   headAddr, headWord  registered head entry
module fetch_queue
  import inst_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = DEF_INST_ADDR_LEN,
  parameter int WORD_W = DEF_INST_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] pushAddr,
  input  logic [WORD_W-1:0] pushWord,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        count,
  output logic [ADDR_W-1:0] headAddr,
  output logic [WORD_W-1:0] headWord
);

  localparam int ENTRY_W = ADDR_W + WORD_W;

  logic [ENTRY_W-1:0] slot0;
  logic [ENTRY_W-1:0] slot1;
  logic [ENTRY_W-1:0] pushEntry;

  assign pushEntry = {pushAddr, pushWord};

  // slot0 is always the head, so decode sees a registered value only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= pushEntry;
          else               slot1 <= pushEntry;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= pushEntry;
          end else begin
            slot0 <= pushEntry;
          end
        end
        default: ;
      endcase
    end
  end

  assign {headAddr, headWord} = slot0;

  noOverflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && !flush && count == 2'd2));

  noUnderflow: assert property (@(posedge clk) disable iff (reset)
    !(pop && !flush && count == 2'd0));

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end between pgmCounter and decode.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   pc                    current PC from pgmCounter
//   pc_branch, pc_target  load request / value back to pgmCounter
//   mem_addr, mem_data    synchronous program memory (1-cycle read latency)
//   ex_branch, ex_target  redirect from execute stage
//   inst_valid, inst_ready, inst_word, inst_addr
//                         valid/ready handshake of the head instruction to decode
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int INST_ADDR_LEN = DEF_INST_ADDR_LEN,
  parameter int INST_LEN      = DEF_INST_LEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [INST_ADDR_LEN-1:0] pc,
  output logic                     pc_branch,
  output logic [INST_ADDR_LEN-1:0] pc_target,
  output logic [INST_ADDR_LEN-1:0] mem_addr,
  input  logic [INST_LEN-1:0]      mem_data,
  input  logic                     ex_branch,
  input  logic [INST_ADDR_LEN-1:0] ex_target,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [INST_LEN-1:0]      inst_word,
  output logic [INST_ADDR_LEN-1:0] inst_addr
);

  logic                     f1Valid;
  logic [INST_ADDR_LEN-1:0] f1Addr;
  logic [1:0]               count;
  logic                     pop;
  logic                     haveCredit;
  logic                     issue;

  assign mem_addr   = pc;
  assign pop        = inst_valid & inst_ready;
  assign haveCredit = creditOk(count, f1Valid, pop);
  assign issue      = haveCredit & ~ex_branch;

  // Without credit the PC is reloaded with itself, so the read made this
  // cycle is simply thrown away and repeated later. A redirect overrides that.
  assign pc_branch = ex_branch | ~haveCredit;
  assign pc_target = ex_branch ? ex_target : pc;

  // Remembers whether the word coming back from memory next cycle is wanted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f1Valid <= 1'b0;
      f1Addr  <= '0;
    end else begin
      f1Valid <= issue;
      f1Addr  <= pc;
    end
  end

  fetch_queue #(
    .ADDR_W (INST_ADDR_LEN),
    .WORD_W (INST_LEN)
  ) queue (
    .clk      (clk),
    .reset    (reset),
    .push     (f1Valid),
    .pushAddr (f1Addr),
    .pushWord (mem_data),
    .pop      (pop),
    .flush    (ex_branch),
    .count    (count),
    .headAddr (inst_addr),
    .headWord (inst_word)
  );

  assign inst_valid = (count != 2'd0);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit. Models pgmCounter and a synchronous
// program memory around the DUT; a scoreboard holds the program-order address
// stream decode should receive and a monitor checks every accepted instruction.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam int AW = DEF_INST_ADDR_LEN;
  localparam int WW = DEF_INST_LEN;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc;
  logic          pc_branch;
  logic [AW-1:0] pc_target;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_data;
  logic          ex_branch;
  logic [AW-1:0] ex_target;
  logic          inst_valid;
  logic          inst_ready;
  logic [WW-1:0] inst_word;
  logic [AW-1:0] inst_addr;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  int cycles = 0;

  logic [WW-1:0] memImage [256];
  logic [AW-1:0] expQ [$];

  logic          sValid, sBranch;
  logic [AW-1:0] sAddr, sTarget, sPc, sMem;
  logic [WW-1:0] sWord;

  inst_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .pc_branch  (pc_branch),
    .pc_target  (pc_target),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .ex_branch  (ex_branch),
    .ex_target  (ex_target),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_word  (inst_word),
    .inst_addr  (inst_addr)
  );

  always #5 clk = ~clk;

  // pgmCounter: load on branch, otherwise count up with natural wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          pc <= '0;
    else if (pc_branch) pc <= pc_target;
    else                pc <= pc + 8'd1;
  end

  // Synchronous program memory.
  always_ff @(posedge clk) begin
    mem_data <= memImage[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Program order from a start address: start, start+1, ... wrapping at 8 bits.
  task automatic reloadExpected(input logic [AW-1:0] start);
    logic [AW-1:0] a;
    a = start;
    expQ.delete();
    for (int i = 0; i < 1024; i++) begin
      expQ.push_back(a);
      a = a + 8'd1;
    end
  endtask

  // Drives one cycle of inputs, snapshots outputs at the falling edge, and
  // returns just after the rising edge that consumed the inputs.
  task automatic applyStimulus(input logic rdy, input logic exb, input logic [AW-1:0] tgt);
    inst_ready = rdy;
    ex_branch  = exb;
    ex_target  = tgt;
    @(negedge clk);
    sValid  = inst_valid;
    sAddr   = inst_addr;
    sWord   = inst_word;
    sBranch = pc_branch;
    sTarget = pc_target;
    sPc     = pc;
    sMem    = mem_addr;
    @(posedge clk);
    #1;
    if (exb) reloadExpected(tgt);
    ex_branch = 1'b0;
  endtask

  // Monitor: every instruction decode accepts must be next in program order.
  always @(negedge clk) begin
    logic [AW-1:0] e;
    cycles++;
    if (cycles > 20000) begin
      $display("[TB] FAIL watchdog: got %0d cycles, want under 20000", cycles);
      $fatal(1, "[TB] watchdog expired");
    end
    if (!reset && inst_valid && inst_ready && !ex_branch) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard: got addr %0h, want no delivery (queue empty)", inst_addr);
      end else begin
        e = expQ.pop_front();
        checkOutput("stream addr", 32'(inst_addr), 32'(e));
        checkOutput("stream word", 32'(inst_word), 32'(memImage[e]));
        pops++;
      end
    end
  end

  initial begin
    logic rdy, exb;
    logic [AW-1:0] tgt;

    for (int i = 0; i < 256; i++) memImage[i] = 16'h0100 + 16'(i);

    reset      = 1'b1;
    inst_ready = 1'b0;
    ex_branch  = 1'b0;
    ex_target  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("reset inst_addr",  32'(inst_addr),  32'd0);
    checkOutput("reset inst_word",  32'(inst_word),  32'd0);

    // Test 1: startup latency and full-rate streaming.
    reloadExpected(8'h00);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t1 valid c0", 32'(sValid), 32'd0);
    checkOutput("t1 mem_addr", 32'(sMem), 32'(sPc));
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t1 valid c1", 32'(sValid), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t1 valid c2", 32'(sValid), 32'd1);
    checkOutput("t1 first addr", 32'(sAddr), 32'h00);
    checkOutput("t1 first word", 32'(sWord), 32'h0100);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("t1 no bubble", 32'(sValid), 32'd1);
      checkOutput("t1 addr", 32'(sAddr), 32'(k));
    end

    // Test 2: back-pressure becomes a PC hold every stalled cycle.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("t2 hold branch", 32'(sBranch), 32'd1);
      checkOutput("t2 hold target", 32'(sTarget), 32'(sPc));
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("t2 no gap", 32'(sValid), 32'd1);
    end

    // Test 3: redirect while the queue is full.
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h40);
    checkOutput("t3 branch", 32'(sBranch), 32'd1);
    checkOutput("t3 target", 32'(sTarget), 32'h40);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t3 flushed c1", 32'(sValid), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t3 flushed c2", 32'(sValid), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t3 target valid", 32'(sValid), 32'd1);
    checkOutput("t3 target addr", 32'(sAddr), 32'h40);
    checkOutput("t3 target word", 32'(sWord), 32'h0140);
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);

    // Test 4: redirect during a hold takes priority.
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t4 holding", 32'(sBranch), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h90);
    checkOutput("t4 branch", 32'(sBranch), 32'd1);
    checkOutput("t4 target", 32'(sTarget), 32'h90);
    repeat (2) applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t4 target addr", 32'(sAddr), 32'h90);

    // Test 5: stream across the address wrap.
    applyStimulus(1'b1, 1'b1, 8'hF8);
    repeat (2) applyStimulus(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("t5 no bubble", 32'(sValid), 32'd1);
      checkOutput("t5 addr", 32'(sAddr), 32'(8'(8'hF8 + k)));
    end

    // Test 6: asynchronous reset with a full queue.
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t6 full before reset", 32'(sValid), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t6 async clear", 32'(inst_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    reloadExpected(8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t6 valid c0", 32'(sValid), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t6 valid c1", 32'(sValid), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t6 valid c2", 32'(sValid), 32'd1);
    checkOutput("t6 restart addr", 32'(sAddr), 32'h00);

    // Random phase: random back-pressure and occasional redirects.
    for (int k = 0; k < 500; k++) begin
      rdy = ($urandom_range(0, 9) < 7);
      exb = ($urandom_range(0, 19) == 0);
      tgt = 8'($urandom);
      applyStimulus(rdy, exb, tgt);
      if (exb) checkOutput("rand redirect target", 32'(sTarget), 32'(tgt));
      else if (sBranch) checkOutput("rand hold target", 32'(sTarget), 32'(sPc));
    end

    checkOutput("stream progressed", 32'(pops > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
